demultiplexer_4_buffered: RTL and testbench

//  Inverse of the 4-way select path: routes one WIDTH-bit word to one of four destinations by sel.

---
 rtl/demultiplexer_4_buffered_pkg.sv | 27 ++
 rtl/demux_slot.sv | 34 +++
 rtl/demultiplexer_4_buffered.sv | 63 ++++++
 tb/tb_demultiplexer_4_buffered.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/demultiplexer_4_buffered_pkg.sv
// Shared constants for the buffered 4-way demultiplexer: channel indices,
// default widths and the select decoder.
package demultiplexer_4_buffered_pkg;

    localparam int DEFAULT_WIDTH     = 32;
    localparam int DEFAULT_CNT_WIDTH = 8;

    localparam logic [1:0] SEL_CH0 = 2'd0;
    localparam logic [1:0] SEL_CH1 = 2'd1;
    localparam logic [1:0] SEL_CH2 = 2'd2;
    localparam logic [1:0] SEL_CH3 = 2'd3;

    function automatic logic [3:0] selDecode(input logic [1:0] sel);
        logic [3:0] oneHot;
        // NOTE: assign a default before the case so no path leaves the result unassigned (no latch).
        oneHot = 4'b0000;
        case (sel)
            SEL_CH0: oneHot = 4'b0001;
            SEL_CH1: oneHot = 4'b0010;
            SEL_CH2: oneHot = 4'b0100;
            SEL_CH3: oneHot = 4'b1000;
            default: oneHot = 4'b0000;
        endcase
        return oneHot;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with a valid/ready handshake. A load in the
// same cycle as a drain replaces the word and keeps valid set.
module demux_slot
    import demultiplexer_4_buffered_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] inData,
    input  logic             outReady,
    output logic             valid,
    output logic [WIDTH-1:0] outData,
    output logic             canLoad
);

    assign canLoad = ~valid | outReady;

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the data register is reset too, because consumers expect zeros on every channel after reset.
            valid   <= 1'b0;
            outData <= '0;
        end else if (load) begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            valid   <= 1'b1;
            outData <= inData;
        end else if (outReady) begin
            valid   <= 1'b0;
        end
    end

endmodule

// File: rtl/demultiplexer_4_buffered.sv
// Routes one word to one of four buffered channels by sel. It holds the select
// decode, the in_ready mux and the wrapping count of accepted words.
module demultiplexer_4_buffered
    import demultiplexer_4_buffered_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           sel,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     out_data_0,
    output logic [WIDTH-1:0]     out_data_1,
    output logic [WIDTH-1:0]     out_data_2,
    output logic [WIDTH-1:0]     out_data_3,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [CNT_WIDTH-1:0] accept_count
);

    logic [3:0]       selOneHot;
    logic [3:0]       slotLoad;
    logic [3:0]       slotCanLoad;
    logic             accept;
    logic [WIDTH-1:0] slotData [4];

    assign selOneHot = selDecode(sel);
    // Readiness looks only at the selected slot, so other channels never block input.
    assign in_ready  = enable & slotCanLoad[sel];
    assign accept    = in_valid & in_ready;
    assign slotLoad  = selOneHot & {4{accept}};

    for (genvar k = 0; k < 4; k++) begin : gSlot
        demux_slot #(.WIDTH(WIDTH)) uSlot (
            .clock    (clock),
            .reset    (reset),
            .load     (slotLoad[k]),
            .inData   (in_data),
            .outReady (out_ready[k]),
            .valid    (out_valid[k]),
            .outData  (slotData[k]),
            .canLoad  (slotCanLoad[k])
        );
    end

    assign out_data_0 = slotData[0];
    assign out_data_1 = slotData[1];
    assign out_data_2 = slotData[2];
    assign out_data_3 = slotData[3];

    always_ff @(posedge clock) begin
        if (reset) begin
            accept_count <= '0;
        end else if (accept) begin
            accept_count <= accept_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_demultiplexer_4_buffered.sv
// Self-checking bench: per-channel scoreboard queues plus a vector table
// with hand-written sequences for stalls, enable and reset.
module tb_demultiplexer_4_buffered;
    import demultiplexer_4_buffered_pkg::*;

    localparam int WIDTH     = 32;
    localparam int CNT_WIDTH = 8;

    logic                 clock;
    logic                 reset;
    logic                 enable;
    logic [1:0]           sel;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data_0;
    logic [WIDTH-1:0]     out_data_1;
    logic [WIDTH-1:0]     out_data_2;
    logic [WIDTH-1:0]     out_data_3;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready;
    logic [CNT_WIDTH-1:0] accept_count;

    demultiplexer_4_buffered #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sel          (sel),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_data_0   (out_data_0),
        .out_data_1   (out_data_1),
        .out_data_2   (out_data_2),
        .out_data_3   (out_data_3),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .accept_count (accept_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]       sel;
        logic [WIDTH-1:0] data;
        logic [3:0]       outReady;
        logic             enable;
        logic             inValid;
        logic             expReady;
    } vec_t;

    int                   passCount = 0;
    int                   checkCount = 0;
    logic [WIDTH-1:0]     expQ [4][$];
    logic [CNT_WIDTH-1:0] expCount;
    logic                 holdPending;
    logic [WIDTH+1:0]     heldSelData;
    logic [WIDTH-1:0]     outDataArr [4];
    vec_t                 vecTable [14];

    assign outDataArr[0] = out_data_0;
    assign outDataArr[1] = out_data_1;
    assign outDataArr[2] = out_data_2;
    assign outDataArr[3] = out_data_3;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    endtask

    // Inputs are set just after an edge; checks run 1 ns later, then the edge is taken.
    task automatic cycle(input bit useTable, input logic tableReady);
        logic [3:0] modelValid;
        logic       expReady;
        bit         doAccept;
        bit         wasReset;
        #1;
        for (int k = 0; k < 4; k++) modelValid[k] = (expQ[k].size() != 0);
        expReady = enable & (~modelValid[sel] | out_ready[sel]);
        check("in_ready", 64'(in_ready), 64'(expReady));
        if (useTable) check("vec_in_ready", 64'(in_ready), 64'(tableReady));
        if (holdPending && in_valid && !reset)
            check("protocol_hold", 64'({sel, in_data}), 64'(heldSelData));
        holdPending = in_valid && !expReady && !reset;
        heldSelData = {sel, in_data};
        wasReset    = reset;
        doAccept    = !reset && in_valid && expReady;
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                if (modelValid[k] && out_ready[k])
                    check($sformatf("drain_ch%0d", k), 64'(outDataArr[k]), 64'(expQ[k].pop_front()));
            end
        end
        if (doAccept) begin
            expQ[sel].push_back(in_data);
            expCount = expCount + CNT_WIDTH'(1);
        end
        if (reset) begin
            for (int k = 0; k < 4; k++) expQ[k].delete();
            expCount = '0;
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 4; k++) modelValid[k] = (expQ[k].size() != 0);
        check("out_valid", 64'(out_valid), 64'(modelValid));
        check("accept_count", 64'(accept_count), 64'(expCount));
        for (int k = 0; k < 4; k++) begin
            if (modelValid[k])
                check($sformatf("hold_ch%0d", k), 64'(outDataArr[k]), 64'(expQ[k][0]));
            else if (wasReset)
                check($sformatf("reset_data_ch%0d", k), 64'(outDataArr[k]), 64'd0);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [1:0] s,
                         input logic [WIDTH-1:0] d, input logic v, input logic [3:0] rdy);
        reset     = r;
        enable    = en;
        sel       = s;
        in_data   = d;
        in_valid  = v;
        out_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecTable = '{
            // routing to each channel on consecutive cycles
            '{SEL_CH0, 32'hA0, 4'b1111, 1'b1, 1'b1, 1'b1},
            '{SEL_CH1, 32'hA1, 4'b1111, 1'b1, 1'b1, 1'b1},
            '{SEL_CH2, 32'hA2, 4'b1111, 1'b1, 1'b1, 1'b1},
            '{SEL_CH3, 32'hA3, 4'b1111, 1'b1, 1'b1, 1'b1},
            '{SEL_CH0, 32'h00, 4'b1111, 1'b1, 1'b0, 1'b1},
            // backpressure on channel 2, then drain and load on one edge
            '{SEL_CH2, 32'h11, 4'b1011, 1'b1, 1'b1, 1'b1},
            '{SEL_CH2, 32'h22, 4'b1011, 1'b1, 1'b1, 1'b0},
            '{SEL_CH2, 32'h22, 4'b1111, 1'b1, 1'b1, 1'b1},
            '{SEL_CH2, 32'h00, 4'b1011, 1'b1, 1'b0, 1'b0},
            '{SEL_CH0, 32'h00, 4'b1111, 1'b1, 1'b0, 1'b1},
            // channel 1 stalled while channel 3 accepts
            '{SEL_CH1, 32'h44, 4'b1101, 1'b1, 1'b1, 1'b1},
            '{SEL_CH3, 32'h55, 4'b1101, 1'b1, 1'b1, 1'b1},
            '{SEL_CH1, 32'h00, 4'b1101, 1'b1, 1'b0, 1'b0},
            '{SEL_CH1, 32'h00, 4'b1111, 1'b1, 1'b0, 1'b1}
        };
        holdPending = 1'b0;
        heldSelData = '0;
        expCount    = '0;

        // Bring the design out of its unknown power-up state, then check two reset cycles.
        drive(1'b1, 1'b1, SEL_CH0, 32'hDEAD, 1'b1, 4'b0000);
        @(posedge clock);
        #1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);

        foreach (vecTable[i]) begin
            drive(1'b0, vecTable[i].enable, vecTable[i].sel, vecTable[i].data,
                  vecTable[i].inValid, vecTable[i].outReady);
            cycle(1'b1, vecTable[i].expReady);
        end

        // Disabled input stalls while a held word still drains.
        drive(1'b0, 1'b1, SEL_CH0, 32'h77, 1'b1, 4'b0000); cycle(1'b1, 1'b1);
        drive(1'b0, 1'b0, SEL_CH0, 32'h88, 1'b1, 4'b0001); cycle(1'b1, 1'b0);
        drive(1'b0, 1'b0, SEL_CH0, 32'h88, 1'b1, 4'b0001); cycle(1'b1, 1'b0);
        drive(1'b0, 1'b1, SEL_CH0, 32'h00, 1'b0, 4'b0000); cycle(1'b0, 1'b0);

        // Reset discards a held word.
        drive(1'b0, 1'b1, SEL_CH0, 32'h99, 1'b1, 4'b0000); cycle(1'b1, 1'b1);
        drive(1'b1, 1'b1, SEL_CH0, 32'h00, 1'b0, 4'b0000); cycle(1'b0, 1'b0);

        // 256 accepts wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 2'(i % 4), $urandom, 1'b1, 4'b1111);
            cycle(1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, SEL_CH0, 32'h00, 1'b0, 4'b1111);
        cycle(1'b0, 1'b0);
        check("wrap_count", 64'(accept_count), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
